// File: rtl/alu_multicycle.sv
// Registered integer unit with start/done handshake: single-cycle ALU ops plus
// iterative shift-add multiply and restoring divide/remainder.
`timescale 1ns/1ps
module alu_multicycle #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [1:0]      dbg_state
);
    // Handshake: a request is taken on any rising edge with start=1 while busy=0;
    // done pulses for exactly one cycle with result/zero valid, never alongside busy.
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0]  LAST_CNT = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    logic [1:0]      state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;
    logic            eq_q, eq_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            is_div_op, div_signed, is_rem_op, div_by_zero, div_ovf;
    logic [XLEN-1:0] fast_res, a_mag, b_mag;
    logic [XLEN-1:0] mul_sum;
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_rem, div_quo, quo_fixed, rem_fixed;

    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD, OP_ADDI: alu_res = a + b;
            OP_SUB:          alu_res = a - b;
            OP_AND:          alu_res = a & b;
            OP_OR:           alu_res = a | b;
            OP_XOR:          alu_res = a ^ b;
            OP_SLT:          alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:         alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL:          alu_res = a << shamt;
            OP_SRL:          alu_res = a >> shamt;
            OP_SRA:          alu_res = $unsigned($signed(a) >>> shamt);
            default:         alu_res = '0;
        endcase
    end

    // Opcodes 11xx are the divide family; bit 0 selects unsigned, bit 1 selects remainder.
    assign is_div_op   = op[3] & op[2];
    assign div_signed  = is_div_op & ~op[0];
    assign is_rem_op   = op[1];
    assign div_by_zero = (b == '0);
    assign div_ovf     = (a == MOST_NEG) && (b == ALL_ONES);
    assign fast_res    = div_by_zero ? (is_rem_op ? a : ALL_ONES) : (is_rem_op ? '0 : a);
    assign a_mag       = (div_signed && a[XLEN-1]) ? -a : a;
    assign b_mag       = (div_signed && b[XLEN-1]) ? -b : b;

    assign mul_sum = opb_q[0] ? (acc_q + opa_q) : acc_q;

    // Partial remainder stays below the divisor, so the top bit of the
    // difference is a clean borrow flag.
    assign div_shift = {acc_q, opa_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_quo   = {opa_q[XLEN-2:0], div_ge};
    assign quo_fixed = neg_quo_q ? -div_quo : div_quo;
    assign rem_fixed = neg_rem_q ? -div_rem : div_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        eq_d      = eq_q;
        result_d  = result_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        opa_d   = a;
                        opb_d   = b;
                        eq_d    = (a == b);
                    end else if (is_div_op && !div_by_zero && !(div_signed && div_ovf)) begin
                        state_d   = S_DIV;
                        cnt_d     = '0;
                        acc_d     = '0;
                        opa_d     = a_mag;
                        opb_d     = b_mag;
                        neg_quo_d = div_signed & (a[XLEN-1] ^ b[XLEN-1]);
                        neg_rem_d = div_signed & a[XLEN-1];
                        is_rem_d  = is_rem_op;
                        eq_d      = (a == b);
                    end else begin
                        done_d   = 1'b1;
                        result_d = is_div_op ? fast_res : alu_res;
                        zero_d   = (a == b);
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    result_d = mul_sum;
                    zero_d   = eq_q;
                end
            end
            S_DIV: begin
                acc_d = div_rem;
                opa_d = div_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    result_d = is_rem_q ? rem_fixed : quo_fixed;
                    zero_d   = eq_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            eq_q      <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            eq_q      <= eq_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed corner cases plus random ops checked
// against a plain-arithmetic reference model (64-bit and 32-bit instances).
`timescale 1ns/1ps
module tb_alu_multicycle;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        busy, done, zero;
    logic [63:0] result;
    logic [1:0]  dbg_state;

    logic        start32;
    logic [3:0]  op32;
    logic [31:0] a32, b32;
    logic        busy32, done32, zero32;
    logic [31:0] result32;
    logic [1:0]  dbg_state32;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(64)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .dbg_state(dbg_state)
    );

    alu_multicycle #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32), .zero(zero32), .dbg_state(dbg_state32)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the specification's rules in plain 64-bit arithmetic.
    function automatic logic [63:0] ref_alu(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [63:0] sx, sy;
        int sh;
        sx = x;
        sy = y;
        sh = int'(y[5:0]);
        case (o)
            4'd0, 4'd6: return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return (sx < sy) ? 64'd1 : 64'd0;
            4'd7:  return (x < y) ? 64'd1 : 64'd0;
            4'd8:  return x << sh;
            4'd9:  return x >> sh;
            4'd10: return 64'(sx >>> sh);
            4'd11: return x * y;
            4'd12: return (y == 0) ? ONES : (x == MIN64 && y == ONES) ? x : 64'(sx / sy);
            4'd13: return (y == 0) ? ONES : x / y;
            4'd14: return (y == 0) ? x : (x == MIN64 && y == ONES) ? 64'd0 : 64'(sx % sy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_iter(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        if (o == 4'd11) return 1'b1;
        if (o < 4'd12) return 1'b0;
        if (y == 0) return 1'b0;
        if ((o == 4'd12 || o == 4'd14) && x == MIN64 && y == ONES) return 1'b0;
        return 1'b1;
    endfunction

    // Issue one op (called in the cycle where start is raised) and return in its done cycle.
    // A nonzero poke raises an ADD start in that busy cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] exp_res, input int poke);
        int exp_lat, cyc, busy_cnt;
        logic [63:0] prev, exp_r;
        logic held;
        exp_lat = is_iter(o, x, y) ? 65 : 1;
        exp_q.push_back(exp_res);
        prev = result;
        held = 1'b1;
        busy_cnt = 0;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            busy_cnt += int'(busy);
            if (result !== prev) held = 1'b0;
            if (poke != 0 && cyc == poke) begin
                start = 1'b1; op = 4'd0; a = 64'd1; b = 64'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        exp_r = exp_q.pop_front();
        check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        if (exp_lat > 1) check({tag, ".result_held"}, 64'(held), 64'd1);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".zero"}, 64'(zero), 64'(x == y));
    endtask

    initial begin
        logic [3:0]  ro;
        logic [63:0] rx, ry;
        int          sv;
        int          cyc, busy_cnt;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        repeat (3) tick();
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.result", result, 64'd0);
        check("reset.zero", 64'(zero), 64'd0);
        rst = 1'b0;

        // Reset in the middle of a multiply
        start = 1'b1; op = 4'd11; a = 64'd3; b = 64'd3;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset.busy", 64'(busy), 64'd0);
        check("midreset.done", 64'(done), 64'd0);

        run_op("add", 4'd0, 64'd5, -64'sd3, 64'd2, 0);

        // SLT then SLTU back to back
        start = 1'b1; op = 4'd5; a = ONES; b = 64'd1;
        tick();
        check("slt.done", 64'(done), 64'd1);
        check("slt.result", result, 64'd1);
        op = 4'd7;
        tick();
        start = 1'b0;
        check("sltu.done", 64'(done), 64'd1);
        check("sltu.result", result, 64'd0);
        tick();
        check("sltu.done_drop", 64'(done), 64'd0);

        run_op("sra", 4'd10, MIN64, 64'h104, 64'hF800_0000_0000_0000, 0);
        run_op("sll", 4'd8, 64'd1, 64'd63, MIN64, 0);
        run_op("mul", 4'd11, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 10);
        run_op("div_signed", 4'd12, -64'sd7, 64'd2, -64'sd3, 0);
        run_op("rem_signed", 4'd14, -64'sd7, 64'd2, ONES, 0);
        run_op("divu", 4'd13, 64'd100, 64'd7, 64'd14, 0);
        run_op("remu", 4'd15, 64'd100, 64'd7, 64'd2, 0);
        run_op("div_by0", 4'd12, 64'd9, 64'd0, ONES, 0);
        run_op("rem_by0", 4'd14, 64'd9, 64'd0, 64'd9, 0);
        run_op("div_ovf", 4'd12, MIN64, ONES, MIN64, 0);
        run_op("rem_ovf", 4'd14, MIN64, ONES, 64'd0, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin rx = {$urandom, $urandom}; ry = {$urandom, $urandom}; end
                1: begin
                    sv = int'($urandom_range(0, 200)) - 100; rx = 64'(longint'(sv));
                    sv = int'($urandom_range(0, 200)) - 100; ry = 64'(longint'(sv));
                end
                2: begin
                    rx = ($urandom_range(0, 1) == 1) ? MIN64 : {$urandom, $urandom};
                    ry = ($urandom_range(0, 1) == 1) ? 64'd0 : ONES;
                end
                default: begin rx = {$urandom, $urandom}; ry = rx; end
            endcase
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry, ref_alu(ro, rx, ry), 0);
        end

        // Abort a DIVU in its 20th busy cycle
        run_op("pre_abort", 4'd0, 64'd40, 64'd2, 64'd42, 0);
        start = 1'b1; op = 4'd13; a = 64'd1000; b = 64'd7;
        tick();
        start = 1'b0;
        repeat (19) tick();
        check("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.result", result, 64'd0);
        check("abort.zero", 64'(zero), 64'd0);
        tick();
        check("abort.no_done", 64'(done), 64'd0);
        run_op("add_eq", 4'd0, 64'd4, 64'd4, 64'd8, 0);

        // 32-bit instance: MUL 0xFFFF_FFFF x 2
        start32 = 1'b1; op32 = 4'd11; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
        tick();
        start32 = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!done32 && cyc < 100) begin
            busy_cnt += int'(busy32);
            tick();
            cyc++;
        end
        check("mul32.latency", 64'(cyc), 64'd33);
        check("mul32.busy_cycles", 64'(busy_cnt), 64'd32);
        check("mul32.busy_at_done", 64'(busy32), 64'd0);
        check("mul32.result", 64'(result32), 64'h0000_0000_FFFF_FFFE);
        check("mul32.zero", 64'(zero32), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised successor to the single-cycle datapath ALU: a registered, start/done-handshaked integer unit of configurable width. It keeps the base ALU operations, adds unsigned compare and shifts, and adds iterative multiply, divide and remainder. It sits in the execute stage. The control unit holds the pipeline while `busy` is high.

## Interface
- `XLEN`, default 64: operand and result width; any value ≥ 8 is legal; `SHW = $clog2(XLEN)`.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: request. It is accepted only on a rising edge where `busy`=0.
- `op  in  4`: operation, sampled with `start`.
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 ADDI (same as ADD)
  - 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA
  - 1011 MUL, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU
- `a  in  XLEN`: operand A, sampled with `start`.
- `b  in  XLEN`: operand B, sampled with `start`.
- `busy  out  1`: an iterative operation is in progress.
- `done  out  1`: one-cycle pulse; `result` and `zero` are valid in this cycle.
- `result  out  XLEN`: registered result; it holds its value until the next `done`.
- `zero  out  1`: registered `a == b` of the accepted operands (BNE/BEQ flag); it updates with `done`.

## Operation
- FSM states: IDLE, MUL, DIV. Reset enters IDLE.
- **Accept:** on an edge in IDLE with `start`=1, latch `op`, `a` and `b`. Compute `zero` from the latched operands.
- **Single-cycle ops** (ADD through SRA, plus the DIV fast paths):
  - `result` is written and `done`=1 on the same edge that accepts the request.
  - The FSM stays in IDLE.
- **Arithmetic:**
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT is a signed compare; SLTU is an unsigned compare. Both produce zero-extended 1 or 0.
  - Shift amount is `b[SHW-1:0]`; upper bits of `b` are ignored. SRA replicates `a[XLEN-1]`.
- **MUL:**
  - Shift-add over XLEN iterations, one multiplier bit per cycle.
  - The result is the low XLEN bits of the product; this is identical for signed and unsigned operands.
  - State goes IDLE→MUL, then MUL→IDLE after XLEN iterations.
- **DIV, DIVU, REM, REMU:**
  - Restoring division on magnitudes, one quotient bit per cycle, XLEN iterations.
  - Signed ops take operand magnitudes, then fix signs: quotient is negative iff the operand signs differ; remainder takes the sign of `a`. Quotient truncates toward zero.
  - State goes IDLE→DIV, then DIV→IDLE.
- **DIV fast paths** (no iteration; `done` on the accept edge):
  - `b`=0: DIV/DIVU give all ones; REM/REMU give `a`.
  - Signed overflow (`a` = most-negative value, `b` = -1): DIV gives `a`; REM gives 0.
- **`start` while `busy`:** ignored, no effect. The requester must hold its request until it is accepted.
- **Reset:**
  - Any edge with `rst`=1 aborts the current operation and returns to IDLE.
  - It clears `busy`, `done`, `result`, `zero` and all internal registers.
  - `rst` has priority over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `zero`=0.
- Edge k is the edge that accepts the request.
- Single-cycle ops and fast paths: `done`=1 in cycle k+1. Latency is 1 and throughput is one op per cycle, since back-to-back `start` is legal.
- MUL and iterative DIV:
  - `busy`=1 in cycles k+1 through k+XLEN.
  - `done`=1 and `busy`=0 in cycle k+XLEN+1.
  - A new `start` is accepted on the edge that ends cycle k+XLEN+1.
- `done` is never high together with `busy`.
- `result` does not change except on the edge that raises `done`, or on reset.
- No combinational path from inputs to outputs.

## Test plan
- **Reset and single-cycle ops** (XLEN=64): assert reset mid-stream, then deassert. Issue ADD 5+(-3) → `result`=2, `zero`=0, `done` one cycle later. Then SLT -1<1 → 1 and SLTU -1<1 → 0, back-to-back, with `done` on two consecutive cycles.
- **Shifts:**
  - SRA 0x8000_0000_0000_0000 by `b`=0x104 → 0xF800_0000_0000_0000 (amount 4).
  - SLL 1 by 63 → 0x8000_0000_0000_0000.
- **MUL:** -3 × 7 → -21 (0xFFFF_FFFF_FFFF_FFEB).
  - `busy` high exactly 64 cycles, `done` at cycle 65.
  - A `start` with ADD issued during `busy` has no effect.
- **Division signs:**
  - DIV -7/2 → -3; REM -7/2 → -1.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Each takes 65 cycles to `done`.
- **Division corners:**
  - DIV 9/0 → 0xFFFF_FFFF_FFFF_FFFF; REM 9/0 → 9. Each has `done` at cycle 1.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM for the same operands → 0.
- **Abort and zero flag:**
  - Assert `rst` in cycle 20 of a DIVU → next cycle `busy`=0, `result`=0, no `done` pulse.
  - A following ADD 4+4 with `a`=`b` completes normally with `result`=8 and `zero`=1.
  - Repeat with XLEN=32 using MUL 0xFFFF_FFFF × 2 → 0xFFFF_FFFE, 32 busy cycles.
